// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and default 125 MHz timing for the button classifier
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT_GAP  = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_e;

  localparam int unsigned DEF_LONG_TIME = 32'd500000000;  // 4 s at 125 MHz
  localparam int unsigned DEF_GAP_TIME  = 32'd31250000;   // 250 ms at 125 MHz

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - per-state cycle counter with sync clear, enable and limit compare
module hold_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == limit_i);

endmodule

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - classifies debounced presses into short, double and long events
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int unsigned LONG_TIME = DEF_LONG_TIME,
  parameter int unsigned GAP_TIME  = DEF_GAP_TIME,
  parameter int unsigned CNT_W     = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_short,
  output logic o_double,
  output logic o_long,
  output logic o_held
);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_TIME - 1);

  state_e state_q, state_d;
  logic   btn_q;
  logic   short_q, short_d;
  logic   double_q, double_d;
  logic   long_q, long_d;
  logic   held_q, held_d;
  logic   rise;
  logic   tmr_clr, tmr_en, tmr_hit;
  logic [CNT_W-1:0] tmr_limit;

  assign rise = i_btn & ~btn_q;

  // Counter restarts on every state change and only runs in the timed states.
  assign tmr_clr   = (state_d != state_q);
  assign tmr_en    = (state_q == PRESS1) || (state_q == WAIT_GAP) || (state_q == PRESS2);
  assign tmr_limit = (state_q == WAIT_GAP) ? GAP_LIM : LONG_LIM;

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .hit_o   (tmr_hit)
  );

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (!i_btn) begin
          state_d = WAIT_GAP;
        end else if (tmr_hit) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      WAIT_GAP: begin
        // A new press wins over gap expiry landing in the same cycle.
        if (i_btn) begin
          state_d = PRESS2;
        end else if (tmr_hit) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (!i_btn) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else if (tmr_hit) begin
          state_d = LONG_HELD;
          short_d = 1'b1;
          long_d  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!i_btn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d == LONG_HELD);
  end

  // btn_q resets high so a button held through reset must be released first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      btn_q    <= 1'b1;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_q    <= i_btn;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      held_q   <= held_d;
    end
  end

  assign o_short  = short_q;
  assign o_double = double_q;
  assign o_long   = long_q;
  assign o_held   = held_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// tb/tb_button_press_classifier.sv - scoreboard bench for button_press_classifier (LONG=8, GAP=4)
module tb_button_press_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_btn = 1'b0;
  logic o_short, o_double, o_long, o_held;

  typedef struct {
    int         cyc;
    logic [3:0] vec;  // {short, double, long, held}
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic held_prev = 1'b0;

  button_press_classifier #(
    .LONG_TIME (8),
    .GAP_TIME  (4),
    .CNT_W     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (i_btn),
    .o_short  (o_short),
    .o_double (o_double),
    .o_long   (o_long),
    .o_held   (o_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any pulse or held-level change is an event to match against the queue.
  always @(negedge clk) begin
    logic [3:0] act;
    ev_t        e;
    act = {o_short, o_double, o_long, o_held};
    if (o_short || o_double || o_long || (o_held != held_prev)) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event cyc=%0d actual=%b required=none", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc == cyc && e.vec == act) begin
          n_pass++;
        end else begin
          $display("FAIL event actual cyc=%0d vec=%b required cyc=%0d vec=%b",
                   cyc, act, e.cyc, e.vec);
        end
      end
    end
    held_prev = o_held;
  end

  function automatic void expect_ev(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  task automatic drive(input logic b, input int n);
    repeat (n) begin
      i_btn = b;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t, f, r;

    rst = 1'b1;
    drive(1'b0, 3);
    rst = 1'b0;
    chk("reset_short", int'(o_short), 0);
    chk("reset_double", int'(o_double), 0);
    chk("reset_long", int'(o_long), 0);
    chk("reset_held", int'(o_held), 0);
    drive(1'b0, 3);

    // short press: 3 high, fall at F -> short at F+5
    drive(1'b1, 3);
    f = cyc;
    expect_ev(f + 5, 4'b1000);
    drive(1'b0, 10);

    // long press: rise at T -> long+held at T+9, held drops R+1
    t = cyc;
    expect_ev(t + 9, 4'b0011);
    drive(1'b1, 20);
    r = cyc;
    expect_ev(r + 1, 4'b0000);
    drive(1'b0, 10);

    // double press: 2 high, 2 low, 2 high -> double at T+7
    t = cyc;
    expect_ev(t + 7, 4'b0100);
    drive(1'b1, 2);
    drive(1'b0, 2);
    drive(1'b1, 2);
    drive(1'b0, 10);

    // gap boundary: second rise while WAIT_GAP counter == 3 -> double
    t = cyc;
    expect_ev(t + 9, 4'b0100);
    drive(1'b1, 2);
    drive(1'b0, 4);
    drive(1'b1, 2);
    drive(1'b0, 10);

    // one cycle later: short from first press, new press classified afresh
    t = cyc;
    expect_ev(t + 7, 4'b1000);
    expect_ev(t + 15, 4'b1000);
    drive(1'b1, 2);
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 12);

    // reset with button held: ignored until released and pressed again
    rst = 1'b1;
    drive(1'b1, 3);
    rst = 1'b0;
    drive(1'b1, 15);
    drive(1'b0, 2);
    t = cyc;
    expect_ev(t + 8, 4'b1000);
    drive(1'b1, 3);
    drive(1'b0, 10);

    // reset mid-PRESS1 at counter 5: no long press afterwards
    t = cyc;
    drive(1'b1, 6);
    rst = 1'b1;
    drive(1'b1, 1);
    rst = 1'b0;
    chk("midrst_cycle", cyc, t + 7);
    chk("midrst_outputs", int'({o_short, o_double, o_long, o_held}), 0);
    drive(1'b1, 20);
    drive(1'b0, 10);

    // reset during LONG_HELD drops held on the next cycle
    t = cyc;
    expect_ev(t + 9, 4'b0011);
    drive(1'b1, 12);
    r = cyc;
    expect_ev(r + 1, 4'b0000);
    rst = 1'b1;
    drive(1'b1, 1);
    rst = 1'b0;
    chk("heldrst_held", int'(o_held), 0);
    drive(1'b1, 12);
    drive(1'b0, 10);

    chk("events_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
